mem_arbiter_n: RTL and testbench
================================

MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 SHALL have parameter N_PORTS, default 2: number of upstream requesters, legal range 2..8.
REQ-002 SHALL have parameter S_LINE, default 256: line width in bits.
REQ-003 SHALL have parameter S_ADDR, default 32: address width in bits.
REQ-004 SHALL provide clk input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL provide rst input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL provide up_read input, N_PORTS bits: per-port line read request.
REQ-007 SHALL provide up_write input, N_PORTS bits: per-port line write request.
REQ-008 SHALL provide up_address input, N_PORTS x S_ADDR: per-port line address.
REQ-009 SHALL provide up_wdata input, N_PORTS x S_LINE: per-port write line.
REQ-010 SHALL provide up_rdata output, S_LINE bits: registered read line, shared by all ports.
REQ-011 SHALL provide up_resp output, N_PORTS bits: per-port completion pulse.
REQ-012 SHALL provide dn_read and dn_write outputs, 1 bit each: downstream request.
REQ-013 SHALL provide dn_address output (S_ADDR bits) and dn_wdata output (S_LINE bits).
REQ-014 SHALL provide dn_resp input (1 bit) and dn_rdata input (S_LINE bits).

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-016 In IDLE with any request pending:
- Grant exactly one port by round-robin, searching from last_grant+1 modulo N_PORTS.
- Latch port index, op, address and wdata.
- Go to BUSY.
REQ-017 In IDLE with no request pending, SHALL stay in IDLE with all outputs deasserted.
REQ-018 In BUSY, dn_read or dn_write SHALL be driven from latched registers only, never from live upstream inputs.
REQ-019 In BUSY, on dn_resp: latch dn_rdata into up_rdata for reads; drop dn_read/dn_write in that same cycle's next state; go to DONE.
REQ-020 In DONE:
- up_resp[grant] is high for exactly one cycle; all other up_resp bits are low.
- last_grant is updated to the granted port.
- Next state is IDLE.
REQ-021 Latency: request in cycle 0 -> dn request in cycle 1 -> dn_resp in cycle k -> up_resp in cycle k+1; IDLE resamples in cycle k+2.
REQ-022 When up_read and up_write are both high on one port, write SHALL take priority.
REQ-023 A request that drops while BUSY SHALL still complete, and its up_resp SHALL still pulse.
REQ-024 Requesters SHALL deassert in the cycle after up_resp; a request held high SHALL be served again, subject to round-robin.
REQ-025 For writes, up_rdata SHALL hold its prior value.
REQ-026 When N_PORTS is not a power of two, round-robin SHALL skip indices >= N_PORTS.
REQ-027 With all ports requesting continuously, each port SHALL be served once every N_PORTS transactions.

Reset
REQ-028 rst SHALL asynchronously force:
- state = IDLE
- last_grant = N_PORTS-1, so port 0 wins first
- up_resp = 0, dn_read = 0, dn_write = 0
- up_rdata, dn_address, dn_wdata = 0
REQ-029 rst asserted mid-BUSY SHALL abort the transaction with no up_resp pulse; downstream tolerates the dropped request.

Structure
REQ-030 Package arb_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the op enum (OP_READ/OP_WRITE).
REQ-031 One combinational sub-module, rr_picker, SHALL take the request vector and last_grant and return a valid bit and the grant index.
REQ-032 The line-width data path SHALL be one S_LINE register for rdata and one for wdata.

Verification
REQ-033 N_PORTS=2, reset, then port1 read 0x0000_1000, dn_resp after 3 cycles with 0xAB..AB -> dn_read in cycles 1-3, up_resp[1] in cycle 4, up_rdata = 0xAB..AB.
REQ-034 N_PORTS=2, port0 and port1 request together from reset -> port0 served first, then port1; never two up_resp bits high together.
REQ-035 N_PORTS=3, all ports held requesting for 6 transactions -> grant order 0,1,2,0,1,2.
REQ-036 Port0 write to 0x40 with wdata 0x55..55, port0 address/wdata changed during BUSY -> dn_address = 0x40 and dn_wdata = 0x55..55 throughout; up_rdata unchanged.
REQ-037 Port1 read and write both high -> dn_write asserted.
REQ-038 rst pulsed mid-BUSY -> dn_read = 0 immediately, no up_resp, next request granted to port0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the N-port line arbiter: FSM states and latched operation kind.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage : arb_pkg

// File: rtl/rr_picker.sv
// Round-robin grant picker: first requesting port after last_grant, wrapping modulo N_PORTS.
module rr_picker #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned W_IDX   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [W_IDX-1:0]   i_last_grant,
    output logic               o_valid_c,
    output logic [W_IDX-1:0]   o_grant_c
);

    logic [W_IDX-1:0] w_cand;

    // Walk candidates last+1 .. last+N_PORTS; the modulo keeps indices below N_PORTS.
    always_comb begin
        o_valid_c = 1'b0;
        o_grant_c = '0;
        w_cand    = '0;
        for (int unsigned off = 1; off <= N_PORTS; off++) begin
            w_cand = W_IDX'((32'(i_last_grant) + off) % N_PORTS);
            if (!o_valid_c && i_req[w_cand]) begin
                o_valid_c = 1'b1;
                o_grant_c = w_cand;
            end
        end
    end

endmodule : rr_picker

// File: rtl/mem_arbiter_n.sv
// N-port line-memory arbiter: one downstream transaction at a time, round-robin grant.
module mem_arbiter_n
    import arb_pkg::*;
#(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned S_LINE  = 256,
    parameter int unsigned S_ADDR  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          up_read,
    input  logic [N_PORTS-1:0]          up_write,
    input  logic [N_PORTS*S_ADDR-1:0]   up_address,
    input  logic [N_PORTS*S_LINE-1:0]   up_wdata,
    output logic [S_LINE-1:0]           up_rdata,
    output logic [N_PORTS-1:0]          up_resp,
    output logic                        dn_read,
    output logic                        dn_write,
    output logic [S_ADDR-1:0]           dn_address,
    output logic [S_LINE-1:0]           dn_wdata,
    input  logic                        dn_resp,
    input  logic [S_LINE-1:0]           dn_rdata
);

    localparam int unsigned W_IDX = $clog2(N_PORTS);

    state_e               r_state;
    state_e               w_state_next;
    logic                 w_start;
    logic                 w_finish;

    logic [W_IDX-1:0]     r_last_grant;
    logic [W_IDX-1:0]     r_grant;
    op_e                  r_op;
    logic [S_ADDR-1:0]    r_dn_address;
    logic [S_LINE-1:0]    r_dn_wdata;
    logic [S_LINE-1:0]    r_up_rdata;
    logic [N_PORTS-1:0]   r_up_resp;
    logic                 r_dn_read;
    logic                 r_dn_write;

    logic [N_PORTS-1:0]   w_req;
    logic                 w_pick_valid;
    logic [W_IDX-1:0]     w_pick_grant;
    op_e                  w_pick_op;
    logic [S_ADDR-1:0]    w_pick_address;
    logic [S_LINE-1:0]    w_pick_wdata;

    assign w_req = up_read | up_write;

    rr_picker #(
        .N_PORTS (N_PORTS),
        .W_IDX   (W_IDX)
    ) u_rr_picker (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_valid_c    (w_pick_valid),
        .o_grant_c    (w_pick_grant)
    );

    // Select the winning port's payload; write wins when a port asserts both read and write.
    always_comb begin
        w_pick_op      = up_write[w_pick_grant] ? OP_WRITE : OP_READ;
        w_pick_address = up_address[32'(w_pick_grant) * S_ADDR +: S_ADDR];
        w_pick_wdata   = up_wdata[32'(w_pick_grant) * S_LINE +: S_LINE];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state plus one-cycle start/finish strobes for the datapath.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = BUSY;
                    w_start      = 1'b1;
                end
            end
            BUSY: begin
                if (dn_resp) begin
                    w_state_next = DONE;
                    w_finish     = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Transaction datapath: latch the granted request, drive downstream from latches, capture read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_op         <= OP_READ;
            r_dn_address <= '0;
            r_dn_wdata   <= '0;
            r_up_rdata   <= '0;
            r_up_resp    <= '0;
            r_dn_read    <= 1'b0;
            r_dn_write   <= 1'b0;
        end else begin
            r_up_resp <= '0;
            if (w_start) begin
                r_grant      <= w_pick_grant;
                r_op         <= w_pick_op;
                r_dn_address <= w_pick_address;
                r_dn_wdata   <= w_pick_wdata;
                r_dn_read    <= (w_pick_op == OP_READ);
                r_dn_write   <= (w_pick_op == OP_WRITE);
            end
            if (w_finish) begin
                r_dn_read  <= 1'b0;
                r_dn_write <= 1'b0;
                if (r_op == OP_READ) begin
                    r_up_rdata <= dn_rdata;
                end
                r_up_resp[r_grant] <= 1'b1;
            end
        end
    end

    // Round-robin pointer advances only once a transaction has fully completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= W_IDX'(N_PORTS - 1);
        end else if (r_state == DONE) begin
            r_last_grant <= r_grant;
        end
    end

    assign up_rdata   = r_up_rdata;
    assign up_resp    = r_up_resp;
    assign dn_read    = r_dn_read;
    assign dn_write   = r_dn_write;
    assign dn_address = r_dn_address;
    assign dn_wdata   = r_dn_wdata;

endmodule : mem_arbiter_n

// File: tb/tb_mem_arbiter_n.sv
// Self-checking bench for mem_arbiter_n: a 2-port/256-bit instance and a 3-port/64-bit instance.
module tb_mem_arbiter_n;

    localparam int unsigned NP2 = 2;
    localparam int unsigned SL2 = 256;
    localparam int unsigned SA2 = 32;
    localparam int unsigned NP3 = 3;
    localparam int unsigned SL3 = 64;
    localparam int unsigned SA3 = 16;

    typedef struct {
        int              port;
        logic [SL2-1:0]  rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 2-port instance signals
    logic [NP2-1:0]     up_read2    = '0;
    logic [NP2-1:0]     up_write2   = '0;
    logic [NP2*SA2-1:0] up_address2 = '0;
    logic [NP2*SL2-1:0] up_wdata2   = '0;
    logic [SL2-1:0]     up_rdata2;
    logic [NP2-1:0]     up_resp2;
    logic               dn_read2;
    logic               dn_write2;
    logic [SA2-1:0]     dn_address2;
    logic [SL2-1:0]     dn_wdata2;
    logic               dn_resp2    = 1'b0;
    logic [SL2-1:0]     dn_rdata2   = '0;

    // 3-port instance signals
    logic [NP3-1:0]     up_read3    = '0;
    logic [NP3-1:0]     up_write3   = '0;
    logic [NP3*SA3-1:0] up_address3 = '0;
    logic [NP3*SL3-1:0] up_wdata3   = '0;
    logic [SL3-1:0]     up_rdata3;
    logic [NP3-1:0]     up_resp3;
    logic               dn_read3;
    logic               dn_write3;
    logic [SA3-1:0]     dn_address3;
    logic [SL3-1:0]     dn_wdata3;
    logic               dn_resp3    = 1'b0;
    logic [SL3-1:0]     dn_rdata3   = '0;

    int checks = 0;
    int errors = 0;

    exp_t           q2[$];
    int             q3[$];
    logic [SL2-1:0] exp_rdata2 = '0;

    int             lat2      = 3;
    int             cnt2      = 0;
    bit             use_fixed = 1'b0;
    logic [SL2-1:0] rsp_fixed = '0;
    int             cnt3      = 0;

    mem_arbiter_n #(.N_PORTS(NP2), .S_LINE(SL2), .S_ADDR(SA2)) dut2 (
        .clk(clk), .rst(rst),
        .up_read(up_read2), .up_write(up_write2), .up_address(up_address2), .up_wdata(up_wdata2),
        .up_rdata(up_rdata2), .up_resp(up_resp2),
        .dn_read(dn_read2), .dn_write(dn_write2), .dn_address(dn_address2), .dn_wdata(dn_wdata2),
        .dn_resp(dn_resp2), .dn_rdata(dn_rdata2)
    );

    mem_arbiter_n #(.N_PORTS(NP3), .S_LINE(SL3), .S_ADDR(SA3)) dut3 (
        .clk(clk), .rst(rst),
        .up_read(up_read3), .up_write(up_write3), .up_address(up_address3), .up_wdata(up_wdata3),
        .up_rdata(up_rdata3), .up_resp(up_resp3),
        .dn_read(dn_read3), .dn_write(dn_write3), .dn_address(dn_address3), .dn_wdata(dn_wdata3),
        .dn_resp(dn_resp3), .dn_rdata(dn_rdata3)
    );

    function automatic logic [SL2-1:0] pat2(input logic [SA2-1:0] a);
        return {8{a}};
    endfunction

    function automatic logic [SL3-1:0] pat3(input logic [SA3-1:0] a);
        return {4{a}};
    endfunction

    // Downstream memory model for the 2-port instance: dn_resp lat2 cycles into a request.
    always @(posedge clk) begin
        #1;
        if (dn_resp2) begin
            dn_resp2 = 1'b0;
            cnt2     = 0;
        end else if (dn_read2 || dn_write2) begin
            cnt2++;
            if (cnt2 >= lat2) begin
                dn_resp2  = 1'b1;
                dn_rdata2 = use_fixed ? rsp_fixed : pat2(dn_address2);
            end
        end else begin
            cnt2 = 0;
        end
    end

    // Downstream memory model for the 3-port instance: responds in the first request cycle.
    always @(posedge clk) begin
        #1;
        if (dn_resp3) begin
            dn_resp3 = 1'b0;
            cnt3     = 0;
        end else if (dn_read3 || dn_write3) begin
            cnt3++;
            if (cnt3 >= 1) begin
                dn_resp3  = 1'b1;
                dn_rdata3 = pat3(dn_address3);
            end
        end else begin
            cnt3 = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port2(input int p, input logic rd, input logic wr,
                             input logic [SA2-1:0] a, input logic [SL2-1:0] d);
        up_read2[p]              = rd;
        up_write2[p]             = wr;
        up_address2[p*SA2 +: SA2] = a;
        up_wdata2[p*SL2 +: SL2]   = d;
    endtask

    task automatic set_port3(input int p, input logic rd, input logic [SA3-1:0] a);
        up_read3[p]              = rd;
        up_write3[p]             = 1'b0;
        up_address3[p*SA3 +: SA3] = a;
        up_wdata3[p*SL3 +: SL3]   = '0;
    endtask

    task automatic wait_resp2(output logic [NP2-1:0] r, output bit timed_out);
        bit seen = 1'b0;
        r = '0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (up_resp2 !== '0) begin
                r    = up_resp2;
                seen = 1'b1;
            end
        end
        timed_out = !seen;
    endtask

    task automatic wait_resp3(output logic [NP3-1:0] r, output bit timed_out);
        bit seen = 1'b0;
        r = '0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (up_resp3 !== '0) begin
                r    = up_resp3;
                seen = 1'b1;
            end
        end
        timed_out = !seen;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (up_resp2 !== '0 || dn_read2 !== 1'b0 || dn_write2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl2: up_resp=%b dn_read=%b dn_write=%b, expected 00 0 0", up_resp2, dn_read2, dn_write2);
        end
        checks++;
        if (up_rdata2 !== '0 || dn_wdata2 !== '0 || dn_address2 !== '0) begin
            errors++;
            $display("FAIL reset_data2: up_rdata=%h dn_wdata=%h dn_address=%h, expected all zero", up_rdata2, dn_wdata2, dn_address2);
        end
        checks++;
        if (up_resp3 !== '0 || dn_read3 !== 1'b0 || dn_write3 !== 1'b0 || up_rdata3 !== '0) begin
            errors++;
            $display("FAIL reset_3port: up_resp=%b dn_read=%b dn_write=%b up_rdata=%h, expected zeros", up_resp3, dn_read3, dn_write3, up_rdata3);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dn_read2 !== 1'b0 || up_resp2 !== '0) begin
            errors++;
            $display("FAIL idle_no_req: dn_read=%b up_resp=%b, expected 0 00", dn_read2, up_resp2);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        lat2      = 3;
        use_fixed = 1'b1;
        rsp_fixed = {32{8'hAB}};
        set_port2(1, 1'b1, 1'b0, 32'h0000_1000, '0);
        q2.push_back('{port: 1, rdata: {32{8'hAB}}});
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (dn_read2 !== 1'b1 || dn_write2 !== 1'b0 || dn_address2 !== 32'h0000_1000 || up_resp2 !== '0) begin
                errors++;
                $display("FAIL read_dn_cycle%0d: dn_read=%b dn_write=%b dn_address=%h up_resp=%b, expected 1 0 00001000 00",
                         c, dn_read2, dn_write2, dn_address2, up_resp2);
            end
        end
        tick();
        e = q2.pop_front();
        exp_rdata2 = e.rdata;
        checks++;
        if (up_resp2 !== NP2'(1 << e.port) || dn_read2 !== 1'b0) begin
            errors++;
            $display("FAIL read_resp_cycle4: up_resp=%b dn_read=%b, expected %b 0", up_resp2, dn_read2, NP2'(1 << e.port));
        end
        checks++;
        if (up_rdata2 !== e.rdata) begin
            errors++;
            $display("FAIL read_rdata: got %h expected %h", up_rdata2, e.rdata);
        end
        set_port2(1, 1'b0, 1'b0, '0, '0);
        tick();
        checks++;
        if (up_resp2 !== '0) begin
            errors++;
            $display("FAIL read_resp_single_cycle: up_resp=%b expected 00", up_resp2);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_two_ports();
        exp_t           e;
        logic [NP2-1:0] r;
        bit             to;
        lat2 = 2;
        set_port2(0, 1'b1, 1'b0, 32'h0000_0200, '0);
        set_port2(1, 1'b1, 1'b0, 32'h0000_0300, '0);
        q2.push_back('{port: 0, rdata: pat2(32'h0000_0200)});
        q2.push_back('{port: 1, rdata: pat2(32'h0000_0300)});
        for (int t = 0; t < 2; t++) begin
            wait_resp2(r, to);
            checks++;
            if (to || q2.size() == 0) begin
                errors++;
                $display("FAIL two_ports_timeout txn%0d: no up_resp within budget", t);
            end else begin
                e = q2.pop_front();
                exp_rdata2 = e.rdata;
                if (r !== NP2'(1 << e.port) || up_rdata2 !== e.rdata) begin
                    errors++;
                    $display("FAIL two_ports_txn%0d: up_resp=%b up_rdata=%h, expected %b %h", t, r, up_rdata2, NP2'(1 << e.port), e.rdata);
                end
                up_read2 = up_read2 & ~r;
            end
        end
        tick();
        tick();
        checks++;
        if (up_resp2 !== '0 || dn_read2 !== 1'b0) begin
            errors++;
            $display("FAIL two_ports_idle: up_resp=%b dn_read=%b, expected 00 0", up_resp2, dn_read2);
        end
    endtask

    task automatic test_write_hold();
        exp_t e;
        lat2 = 4;
        set_port2(0, 1'b0, 1'b1, 32'h0000_0040, {32{8'h55}});
        q2.push_back('{port: 0, rdata: exp_rdata2});
        for (int c = 1; c <= 4; c++) begin
            tick();
            set_port2(0, 1'b0, 1'b1, 32'hDEAD_0000 + 32'(c), {32{8'hFF}});
            checks++;
            if (dn_write2 !== 1'b1 || dn_read2 !== 1'b0 || dn_address2 !== 32'h0000_0040 || dn_wdata2 !== {32{8'h55}}) begin
                errors++;
                $display("FAIL write_latched_cycle%0d: dn_write=%b dn_read=%b dn_address=%h dn_wdata=%h, expected 1 0 00000040 55..55",
                         c, dn_write2, dn_read2, dn_address2, dn_wdata2);
            end
        end
        tick();
        e = q2.pop_front();
        checks++;
        if (up_resp2 !== NP2'(1 << e.port) || up_rdata2 !== e.rdata) begin
            errors++;
            $display("FAIL write_resp: up_resp=%b up_rdata=%h, expected %b %h", up_resp2, up_rdata2, NP2'(1 << e.port), e.rdata);
        end
        set_port2(0, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_rw_priority();
        exp_t           e;
        logic [NP2-1:0] r;
        bit             to;
        lat2 = 2;
        set_port2(1, 1'b1, 1'b1, 32'h0000_0080, {32{8'h33}});
        q2.push_back('{port: 1, rdata: exp_rdata2});
        tick();
        checks++;
        if (dn_write2 !== 1'b1 || dn_read2 !== 1'b0 || dn_wdata2 !== {32{8'h33}}) begin
            errors++;
            $display("FAIL rw_priority: dn_write=%b dn_read=%b dn_wdata=%h, expected 1 0 33..33", dn_write2, dn_read2, dn_wdata2);
        end
        wait_resp2(r, to);
        e = q2.pop_front();
        checks++;
        if (to || r !== NP2'(1 << e.port) || up_rdata2 !== e.rdata) begin
            errors++;
            $display("FAIL rw_priority_resp: up_resp=%b up_rdata=%h timeout=%0d, expected %b %h", r, up_rdata2, to, NP2'(1 << e.port), e.rdata);
        end
        set_port2(1, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_drop_busy();
        exp_t           e;
        logic [NP2-1:0] r;
        bit             to;
        lat2 = 3;
        set_port2(0, 1'b1, 1'b0, 32'h0000_0500, '0);
        q2.push_back('{port: 0, rdata: pat2(32'h0000_0500)});
        tick();
        set_port2(0, 1'b0, 1'b0, '0, '0);
        wait_resp2(r, to);
        e = q2.pop_front();
        exp_rdata2 = e.rdata;
        checks++;
        if (to || r !== NP2'(1 << e.port) || up_rdata2 !== e.rdata) begin
            errors++;
            $display("FAIL drop_busy: up_resp=%b up_rdata=%h timeout=%0d, expected %b %h", r, up_rdata2, to, NP2'(1 << e.port), e.rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        exp_t           e;
        logic [NP2-1:0] r;
        bit             to;
        lat2 = 20;
        set_port2(1, 1'b1, 1'b0, 32'h0000_0600, '0);
        tick();
        checks++;
        if (dn_read2 !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_pre: dn_read=%b expected 1", dn_read2);
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dn_read2 !== 1'b0 || up_resp2 !== '0 || dn_address2 !== '0) begin
            errors++;
            $display("FAIL rst_busy_async: dn_read=%b up_resp=%b dn_address=%h, expected 0 00 0", dn_read2, up_resp2, dn_address2);
        end
        set_port2(1, 1'b0, 1'b0, '0, '0);
        exp_rdata2 = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (up_resp2 !== '0 || dn_read2 !== 1'b0) begin
                errors++;
                $display("FAIL rst_busy_hold%0d: up_resp=%b dn_read=%b, expected 00 0", c, up_resp2, dn_read2);
            end
        end
        rst  = 1'b0;
        lat2 = 2;
        set_port2(0, 1'b1, 1'b0, 32'h0000_0700, '0);
        set_port2(1, 1'b1, 1'b0, 32'h0000_0800, '0);
        q2.push_back('{port: 0, rdata: pat2(32'h0000_0700)});
        q2.push_back('{port: 1, rdata: pat2(32'h0000_0800)});
        for (int t = 0; t < 2; t++) begin
            wait_resp2(r, to);
            checks++;
            if (to || q2.size() == 0) begin
                errors++;
                $display("FAIL rst_busy_after_timeout txn%0d: no up_resp within budget", t);
            end else begin
                e = q2.pop_front();
                exp_rdata2 = e.rdata;
                if (r !== NP2'(1 << e.port) || up_rdata2 !== e.rdata) begin
                    errors++;
                    $display("FAIL rst_busy_after_txn%0d: up_resp=%b up_rdata=%h, expected %b %h", t, r, up_rdata2, NP2'(1 << e.port), e.rdata);
                end
                up_read2 = up_read2 & ~r;
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t           e;
        logic [NP2-1:0] r;
        bit             to;
        int             exp_last = 1;
        lat2 = 1;
        set_port2(0, 1'b1, 1'b0, 32'h0000_0900, '0);
        set_port2(1, 1'b1, 1'b0, 32'h0000_0A00, '0);
        for (int t = 0; t < 4; t++) begin
            exp_last = (exp_last + 1) % 2;
            q2.push_back('{port: exp_last, rdata: pat2(exp_last == 0 ? 32'h0000_0900 : 32'h0000_0A00)});
        end
        for (int t = 0; t < 4; t++) begin
            wait_resp2(r, to);
            checks++;
            if (to || q2.size() == 0) begin
                errors++;
                $display("FAIL b2b_timeout txn%0d: no up_resp within budget", t);
            end else begin
                e = q2.pop_front();
                exp_rdata2 = e.rdata;
                if (r !== NP2'(1 << e.port) || up_rdata2 !== e.rdata) begin
                    errors++;
                    $display("FAIL b2b_txn%0d: up_resp=%b up_rdata=%h, expected %b %h", t, r, up_rdata2, NP2'(1 << e.port), e.rdata);
                end
            end
        end
        up_read2 = '0;
        tick();
        tick();
        checks++;
        if (dn_read2 !== 1'b0 || up_resp2 !== '0) begin
            errors++;
            $display("FAIL b2b_idle: dn_read=%b up_resp=%b, expected 0 00", dn_read2, up_resp2);
        end
    endtask

    task automatic test_three_ports();
        logic [NP3-1:0] r;
        bit             to;
        int             p;
        int             exp_last = 2;
        set_port3(0, 1'b1, 16'h0010);
        set_port3(1, 1'b1, 16'h0020);
        set_port3(2, 1'b1, 16'h0030);
        for (int t = 0; t < 6; t++) begin
            exp_last = (exp_last + 1) % 3;
            q3.push_back(exp_last);
        end
        for (int t = 0; t < 6; t++) begin
            wait_resp3(r, to);
            checks++;
            if (to || q3.size() == 0) begin
                errors++;
                $display("FAIL three_ports_timeout txn%0d: no up_resp within budget", t);
            end else begin
                p = q3.pop_front();
                if (r !== NP3'(1 << p) || up_rdata3 !== pat3(SA3'(16 * (p + 1)))) begin
                    errors++;
                    $display("FAIL three_ports_txn%0d: up_resp=%b up_rdata=%h, expected %b %h", t, r, up_rdata3, NP3'(1 << p), pat3(SA3'(16 * (p + 1))));
                end
            end
        end
        up_read3 = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_two_ports();
        test_write_hold();
        test_rw_priority();
        test_drop_busy();
        test_reset_mid_busy();
        test_back_to_back();
        test_three_ports();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter_n
